// File: rtl/cpu_nios2_gen2_0_cpu_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_nios2_gen2_0_cpu_mult_seq: two-pass 16x16 cell sequencer and combiner |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cpu_nios2_gen2_0_cpu_mult_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_cell_p1,
  input  logic [31:0] mul_cell_p2,
  input  logic [31:0] mul_cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  localparam logic [1:0] C_OP_MUL    = 2'd0;
  localparam logic [1:0] C_OP_MULXSS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_CAP1   = 3'd2,
    S_CAP2   = 3'd3,
    S_SUM    = 3'd4,
    S_FIX    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [31:0] ll_q, lh_q, hl_q, hh_q, uhi_q;

  logic [32:0] mid;
  logic [63:0] u;
  logic        sign_a, sign_b;
  logic [31:0] fixed;

  assign req_ready = (state == S_IDLE);

  // Unsigned product from partials; signed ops then subtract the two's-complement correction terms.
  always_comb begin
    mid    = {1'b0, lh_q} + {1'b0, hl_q};
    u      = {hh_q, ll_q} + {15'd0, mid, 16'd0};
    sign_a = a_q[31] & op_q[1];
    sign_b = b_q[31] & (op_q == C_OP_MULXSS);
    fixed  = uhi_q - (sign_a ? b_q : 32'd0) - (sign_b ? a_q : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mul_en     <= 1'b0;
      mul_src1   <= 32'd0;
      mul_src2   <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
    end else begin
      mul_en   <= 1'b0;
      mul_src1 <= 32'd0;
      mul_src2 <= 32'd0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q      <= req_src1;
            b_q      <= req_src2;
            op_q     <= req_op;
            mul_src1 <= req_src1;
            mul_src2 <= req_src2;
            mul_en   <= 1'b1;
            state    <= S_ISSUE1;
          end
        end
        S_ISSUE1: begin
          // Half-swapped operands put aH*bH on the cell's low-half product.
          if (op_q != C_OP_MUL) begin
            mul_src1 <= {a_q[15:0], a_q[31:16]};
            mul_src2 <= {b_q[15:0], b_q[31:16]};
            mul_en   <= 1'b1;
          end
          state <= S_CAP1;
        end
        S_CAP1: begin
          ll_q  <= mul_cell_p1;
          lh_q  <= mul_cell_p2;
          hl_q  <= mul_cell_p3;
          state <= (op_q == C_OP_MUL) ? S_SUM : S_CAP2;
        end
        S_CAP2: begin
          hh_q  <= mul_cell_p1;
          state <= S_SUM;
        end
        S_SUM: begin
          if (op_q == C_OP_MUL) begin
            rsp_result <= u[31:0];
            rsp_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            uhi_q <= u[63:32];
            state <= S_FIX;
          end
        end
        S_FIX: begin
          rsp_result <= fixed;
          rsp_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_nios2_gen2_0_cpu_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_nios2_gen2_0_cpu_mult_seq: directed + random checks vs 64-bit model |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_cpu_nios2_gen2_0_cpu_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_src1 = 32'd0;
  logic [31:0] req_src2 = 32'd0;
  logic        req_ready, mul_en, rsp_valid;
  logic [31:0] mul_src1, mul_src2, rsp_result;
  logic [31:0] p1, p2, p3;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_nios2_gen2_0_cpu_mult_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .mul_src1    (mul_src1),
    .mul_src2    (mul_src2),
    .mul_en      (mul_en),
    .mul_cell_p1 (p1),
    .mul_cell_p2 (p2),
    .mul_cell_p3 (p3),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result)
  );

  // Cell model: products valid only the cycle after mul_en, garbage otherwise.
  always @(posedge clk) begin
    if (mul_en) begin
      p1 <= 32'(mul_src1[15:0]) * 32'(mul_src2[15:0]);
      p2 <= 32'(mul_src1[15:0]) * 32'(mul_src2[31:16]);
      p3 <= 32'(mul_src1[31:16]) * 32'(mul_src2[15:0]);
    end else begin
      p1 <= $urandom;
      p2 <= $urandom;
      p3 <= $urandom;
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = (op >= 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (op == 2'd3) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_mul_en"}, 32'(mul_en), 32'd0);
    check({tag, "_mul_src"}, mul_src1 | mul_src2, 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // One transaction; rst_at>0 pulses reset in that cycle after the handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input int rst_at);
    int lat, mask, w;
    logic [31:0] res;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_idle", 32'(req_ready), 32'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    lat = -1; mask = 0; res = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      if (c == rst_at) begin
        req_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        check_idle_outputs("midrst");
        return;
      end
      if (mul_en) mask |= (1 << c);
      if (c == 1) begin
        check("pass1_src1", mul_src1, a);
        check("pass1_src2", mul_src2, b);
      end else if (c == 2 && op != 2'd0) begin
        check("pass2_src1", mul_src1, {a[15:0], a[31:16]});
        check("pass2_src2", mul_src2, {b[15:0], b[31:16]});
      end else if (!mul_en) begin
        check("src_idle", mul_src1 | mul_src2, 32'd0);
      end
      check("busy_ready", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        lat = c;
        res = rsp_result;
        req_valid = 1'b0;
        break;
      end
      // Requests presented while busy must be ignored.
      req_valid = 1'($urandom);
      req_op    = 2'($urandom);
      req_src1  = $urandom;
      req_src2  = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("latency", 32'(lat), (op == 2'd0) ? 32'd4 : 32'd6);
    check("en_mask", 32'(mask), (op == 2'd0) ? 32'h2 : 32'h6);
    check("result", res, exp);
    if (lat > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_result", rsp_result, res);
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_en", 32'(mul_en), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("accepted", 32'(rsp_valid), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;

    run_op(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0), 3, 0);
    run_op(2'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, ref_mul(2'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D), 3, 0);
    run_op(2'd3, 32'h8765_4321, 32'h8000_0001, 32'd0, 0, 3);
    run_op(2'd0, 32'd7, 32'd9, 32'h0000_003F, 0, 0);

    for (int n = 0; n < 10000; n++) begin
      op = 2'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ref_mul(op, a, b), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
